// File: rtl/sdr_types_pkg.sv
// sdr_types_pkg: shared symbol widths, IQ packing and frame sequencer state type
package sdr_types_pkg;
  localparam int SYM_AXI_W = 32;
  typedef struct packed {
    logic [15:0] i;
    logic [15:0] q;
  } iq_t;
  function automatic logic [SYM_AXI_W-1:0] pack_iq(input logic [15:0] i, input logic [15:0] q);
    return {i, q};
  endfunction
  typedef enum logic [2:0] {IDLE, PRE, PAY, PAD, DRAIN, GUARD, FLUSH} seq_state_t;
  localparam logic [SYM_AXI_W-1:0] ZERO_SYM = pack_iq(16'h0, 16'h0);
endpackage

// File: rtl/sym_axis_skid.sv
// sym_axis_skid: 2-entry AXIS register slice with registered outputs and full throughput
module sym_axis_skid #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] s_data,
  input  logic         s_valid,
  output logic         s_ready,
  output logic [W-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready
);
  logic [W-1:0] sk_data;
  logic         sk_valid;
  assign s_ready = !sk_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid  <= 1'b0;
      m_data   <= '0;
      sk_valid <= 1'b0;
      sk_data  <= '0;
    end else if (!sk_valid) begin
      if (!m_valid || m_ready) begin
        m_valid <= s_valid;
        m_data  <= s_valid ? s_data : m_data;
      end else if (s_valid) begin
        sk_valid <= 1'b1;
        sk_data  <= s_data;
      end
    end else if (m_ready) begin
      m_data   <= sk_data;
      sk_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/sym_frame_sequencer.sv
// sym_frame_sequencer: builds preamble/payload/guard symbol frames onto one AXIS master
module sym_frame_sequencer
  import sdr_types_pkg::*;
#(
  parameter int PREAMBLE_LEN = 64,
  parameter int LEN_W        = 16,
  parameter int GUARD_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_W-1:0]     cfg_payload_len,
  input  logic [GUARD_W-1:0]   cfg_guard_len,
  output logic                 busy,
  output logic                 done,
  output logic                 err_short,
  output logic                 err_long,
  input  logic [SYM_AXI_W-1:0] s_pre_tdata,
  input  logic                 s_pre_tvalid,
  output logic                 s_pre_tready,
  input  logic [SYM_AXI_W-1:0] s_pay_tdata,
  input  logic                 s_pay_tvalid,
  input  logic                 s_pay_tlast,
  output logic                 s_pay_tready,
  output logic [SYM_AXI_W-1:0] m_tdata,
  output logic                 m_tvalid,
  output logic                 m_tlast,
  input  logic                 m_tready
);
  seq_state_t           state, tail;
  logic [LEN_W-1:0]     cnt, pay_len;
  logic [GUARD_W-1:0]   grd_len;
  logic [SYM_AXI_W-1:0] in_data;
  logic                 in_valid, in_last, sl_ready, hs, pre_end, pay_end, grd_end, flush_ok;
  always_comb begin
    pre_end      = cnt == LEN_W'(PREAMBLE_LEN - 1);
    pay_end      = cnt == pay_len - LEN_W'(1);
    grd_end      = cnt == LEN_W'(grd_len) - LEN_W'(1);
    tail         = grd_len == '0 ? FLUSH : GUARD;
    in_valid     = state == PRE ? s_pre_tvalid : state == PAY ? s_pay_tvalid : (state == PAD || state == GUARD);
    in_data      = state == PRE ? s_pre_tdata : state == PAY ? s_pay_tdata : ZERO_SYM;
    in_last      = state == PRE ? (pre_end && pay_len == '0 && grd_len == '0) :
                   (state == PAY || state == PAD) ? (pay_end && grd_len == '0) :
                   (state == GUARD && grd_end);
    s_pre_tready = state == PRE && sl_ready;
    s_pay_tready = state == PAY ? sl_ready : state == DRAIN;
    hs           = in_valid && sl_ready;
    flush_ok     = sl_ready && (!m_tvalid || m_tready);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pay_len   <= '0;
      grd_len   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      done      <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
      case (state)
        IDLE: if (start) begin
          pay_len <= cfg_payload_len;
          grd_len <= cfg_guard_len;
          busy    <= 1'b1;
          cnt     <= '0;
          state   <= PRE;
        end
        PRE: if (hs) begin
          cnt   <= pre_end ? '0 : cnt + LEN_W'(1);
          state <= !pre_end ? PRE : pay_len != '0 ? PAY : tail;
        end
        PAY: if (hs) begin
          cnt       <= pay_end ? '0 : cnt + LEN_W'(1);
          err_long  <= pay_end && !s_pay_tlast;
          err_short <= !pay_end && s_pay_tlast;
          state     <= pay_end ? (s_pay_tlast ? tail : DRAIN) : (s_pay_tlast ? PAD : PAY);
        end
        PAD: if (hs) begin
          cnt   <= pay_end ? '0 : cnt + LEN_W'(1);
          state <= pay_end ? tail : PAD;
        end
        DRAIN: if (s_pay_tvalid && s_pay_tlast) state <= tail;
        GUARD: if (hs) begin
          cnt   <= grd_end ? '0 : cnt + LEN_W'(1);
          state <= grd_end ? FLUSH : GUARD;
        end
        FLUSH: if (flush_ok) begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  sym_axis_skid #(.W(SYM_AXI_W + 1)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .s_data  ({in_last, in_data}),
    .s_valid (in_valid),
    .s_ready (sl_ready),
    .m_data  ({m_tlast, m_tdata}),
    .m_valid (m_tvalid),
    .m_ready (m_tready)
  );
endmodule

// File: tb/tb_sym_frame_sequencer.sv
// tb_sym_frame_sequencer: directed frames checked against a frame-level model every output beat
module tb_sym_frame_sequencer;
  logic        clk, rst, start, busy, done, err_short, err_long;
  logic [15:0] cfg_payload_len;
  logic [7:0]  cfg_guard_len;
  logic [31:0] s_pre_tdata, s_pay_tdata, m_tdata;
  logic        s_pre_tvalid, s_pre_tready, s_pay_tvalid, s_pay_tlast, s_pay_tready;
  logic        m_tvalid, m_tlast, m_tready;
  int          checks = 0, failures = 0;
  int          cyc = 0, last_cyc = -10, done_lat = 0, beats = 0;
  int          done_cnt = 0, es_cnt = 0, el_cnt = 0, fr = 0;
  bit          pre_fire = 0, pay_fire = 0, pay_fire_d = 0, prev_stall = 0, bp = 0, no_pay_ready = 0;
  bit          exp_es, exp_el;
  logic [32:0] prev_beat;
  logic [32:0] pre_q[$], pay_q[$], exp_q[$];
  sym_frame_sequencer #(.PREAMBLE_LEN(4), .LEN_W(16), .GUARD_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_payload_len(cfg_payload_len), .cfg_guard_len(cfg_guard_len),
    .busy(busy), .done(done), .err_short(err_short), .err_long(err_long),
    .s_pre_tdata(s_pre_tdata), .s_pre_tvalid(s_pre_tvalid), .s_pre_tready(s_pre_tready),
    .s_pay_tdata(s_pay_tdata), .s_pay_tvalid(s_pay_tvalid), .s_pay_tlast(s_pay_tlast), .s_pay_tready(s_pay_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      pre_fire = 0;
      pay_fire = 0;
      pay_fire_d = 0;
      prev_stall = 0;
    end else begin
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) chk("extra_beat", {m_tlast, m_tdata}, 64'hdead);
        else chk("beat", {m_tlast, m_tdata}, exp_q.pop_front());
        beats++;
        if (m_tlast) last_cyc = cyc;
      end
      if (prev_stall) chk("stall_hold", {m_tvalid, m_tlast, m_tdata}, {1'b1, prev_beat});
      prev_stall = m_tvalid && !m_tready;
      prev_beat = {m_tlast, m_tdata};
      if (done) begin
        done_cnt++;
        done_lat = cyc - last_cyc;
      end
      if (err_short) begin
        es_cnt++;
        chk("err_short_timing", pay_fire, 1);
      end
      if (err_long) begin
        el_cnt++;
        chk("err_long_timing", pay_fire, 1);
      end
      if (no_pay_ready) chk("pay_ready_zero", s_pay_tready, 0);
      pre_fire = s_pre_tvalid && s_pre_tready;
      pay_fire = s_pay_tvalid && s_pay_tready;
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (pre_fire && pre_q.size() > 0) void'(pre_q.pop_front());
    if (pay_fire && pay_q.size() > 0) void'(pay_q.pop_front());
    s_pre_tvalid = pre_q.size() != 0;
    s_pre_tdata = pre_q.size() != 0 ? pre_q[0][31:0] : 32'h0;
    s_pay_tvalid = pay_q.size() != 0;
    {s_pay_tlast, s_pay_tdata} = pay_q.size() != 0 ? pay_q[0] : 33'h0;
    m_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  task automatic build(input int l, input int g, input int n);
    logic [32:0] t;
    fr++;
    for (int i = 0; i < 4; i++) begin
      pre_q.push_back({1'b0, 32'hA000_0000 + 32'(fr * 16 + i)});
      exp_q.push_back({1'b0, 32'hA000_0000 + 32'(fr * 16 + i)});
    end
    for (int j = 0; j < n; j++) begin
      pay_q.push_back({j == n - 1, 32'h5000_0000 + 32'(fr * 256 + j)});
      if (j < l) exp_q.push_back({1'b0, 32'h5000_0000 + 32'(fr * 256 + j)});
    end
    for (int j = n; j < l; j++) exp_q.push_back(33'h0);
    for (int j = 0; j < g; j++) exp_q.push_back(33'h0);
    t = exp_q.pop_back();
    t[32] = 1'b1;
    exp_q.push_back(t);
    exp_es = n < l;
    exp_el = n > l;
  endtask
  task automatic run_frame(input int l, input int g, input int n, input bit bpo, input int tot, input int lat, input bit npr);
    int d0, es0, el0, b0, k;
    build(l, g, n);
    chk("model_len", exp_q.size(), tot);
    chk("model_first", exp_q[0], {1'b0, 32'hA000_0000 + 32'(fr * 16)});
    d0 = done_cnt; es0 = es_cnt; el0 = el_cnt; b0 = beats;
    bp = bpo;
    no_pay_ready = npr;
    cfg_payload_len = 16'(l);
    cfg_guard_len = 8'(g);
    @(posedge clk); #2 start = 1;
    @(posedge clk); #2 start = 0;
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 3000) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("busy_cleared", busy, 0);
    chk("done_count", done_cnt, d0 + 1);
    if (lat != 0) chk("done_latency", done_lat, lat);
    chk("beats", beats - b0, tot);
    chk("exp_empty", exp_q.size(), 0);
    chk("src_consumed", pay_q.size(), 0);
    chk("err_short_cnt", es_cnt - es0, exp_es);
    chk("err_long_cnt", el_cnt - el0, exp_el);
    bp = 0;
    no_pay_ready = 0;
  endtask
  initial begin
    int d0, b0;
    rst = 1; start = 0; cfg_payload_len = 0; cfg_guard_len = 0;
    s_pre_tvalid = 0; s_pre_tdata = 0; s_pay_tvalid = 0; s_pay_tdata = 0; s_pay_tlast = 0; m_tready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {busy, done, err_short, err_long, m_tvalid, m_tlast, m_tdata, s_pre_tready, s_pay_tready}, 0);
    @(posedge clk); #2 rst = 0;
    run_frame(8, 3, 8, 0, 15, 1, 0);
    run_frame(8, 3, 8, 1, 15, 1, 0);
    run_frame(8, 3, 5, 0, 15, 1, 0);
    run_frame(4, 3, 7, 0, 11, 1, 0);
    run_frame(4, 0, 7, 0, 8, 4, 0);
    run_frame(0, 0, 0, 0, 4, 1, 1);
    build(8, 3, 8);
    d0 = done_cnt; b0 = beats;
    cfg_payload_len = 8; cfg_guard_len = 3;
    @(posedge clk); #2 start = 1;
    @(posedge clk); #2 start = 0;
    for (int k = 0; k < 500 && beats < b0 + 6; k++) @(negedge clk);
    chk("reached_pay", beats - b0, 6);
    @(posedge clk); #2 rst = 1;
    pre_q.delete(); pay_q.delete(); exp_q.delete();
    @(posedge clk); #2 rst = 0;
    @(negedge clk);
    chk("rst_abort", {busy, m_tvalid}, 0);
    repeat (10) @(negedge clk);
    chk("no_done_after_rst", done_cnt, d0);
    run_frame(8, 3, 8, 0, 15, 1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
